// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Memory-access stage of the 5-stage RV32 pipeline. Takes the
//               registered EX/MEM fields and performs loads and stores over a
//               req/ack data bus. Upstream stages are stalled while a transfer
//               is outstanding. Load data is aligned and extended, and all
//               fields are then registered into the MEM/WB pipeline register.
//               A transfer that sees no ack for TIMEOUT bus cycles is aborted
//               and flagged on bus_err_w.
// Macro       : MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword and
//               word accesses never reach the bus and are flagged as errors.
//               When undefined, they use the aligned word address, and lanes
//               shifted past byte 3 are dropped.
// Ports       : clk, reset (async, active-high)
//               *_m          EX/MEM inputs (address, store data, rd, PC+4,
//                            regwrite, resultsrc, memwrite, funct3)
//               bus_*        req/ack data bus (word address, replicated
//                            store data, byte strobes, read data, ack)
//               stall_m      hold EX/MEM and earlier stages
//               *_w          MEM/WB outputs, including bus_err_w
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pcplus4_m,
  input  logic        regwrite_m,
  input  logic [1:0]  resultsrc_m,
  input  logic        memwrite_m,
  input  logic [2:0]  funct3_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_m,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pcplus4_w,
  output logic [4:0]  rd_w,
  output logic        regwrite_w,
  output logic [1:0]  resultsrc_w,
  output logic        bus_err_w
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_sign;

  logic        w_access, w_misaligned, w_trap;
  logic [1:0]  w_off, w_size;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_shifted, w_load_data;

  // Access decode. Stores and loads use different funct3 size tables:
  // funct3 bit 2 selects unsigned for loads but means "word" for stores.
  always_comb begin
    w_access = memwrite_m | (resultsrc_m == 2'b01);
    w_off    = alu_result_m[1:0];
    if (memwrite_m) begin
      case (funct3_m)
        3'b000:  w_size = SZ_BYTE;
        3'b001:  w_size = SZ_HALF;
        default: w_size = SZ_WORD;
      endcase
    end else begin
      case (funct3_m)
        3'b000, 3'b100: w_size = SZ_BYTE;
        3'b001, 3'b101: w_size = SZ_HALF;
        default:        w_size = SZ_WORD;
      endcase
    end
    w_misaligned = ((w_size == SZ_HALF) && w_off[0]) ||
                   ((w_size == SZ_WORD) && (w_off != 2'b00));
    w_trap = TRAP_EN && w_misaligned;
  end

  // Store lane steering. A 4-bit shift drops strobes pushed past lane 3.
  always_comb begin
    case (w_size)
      SZ_BYTE: begin
        w_wdata = {4{write_data_m[7:0]}};
        w_wstrb = 4'b0001 << w_off;
      end
      SZ_HALF: begin
        w_wdata = {2{write_data_m[15:0]}};
        w_wstrb = 4'b0011 << w_off;
      end
      default: begin
        w_wdata = write_data_m;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Load alignment and extension from the latched read data.
  always_comb begin
    w_shifted = r_rdata >> {r_off, 3'b000};
    case (r_size)
      SZ_BYTE: w_load_data = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: w_load_data = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Next state and stall. Stall is forced low during reset so the upstream
  // stages are released while the stage is held idle.
  always_comb begin
    w_state_next = r_state;
    stall_m      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          stall_m      = 1'b1;
          w_state_next = w_trap ? DONE : BUS;
        end
      end
      BUS: begin
        stall_m = 1'b1;
        if (bus_ack || (r_cnt == TO_LAST)) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (reset) begin
      stall_m = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_err        <= 1'b0;
      r_rdata      <= 32'd0;
      r_off        <= 2'd0;
      r_size       <= SZ_BYTE;
      r_sign       <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'd0;
      bus_wdata    <= 32'd0;
      bus_wstrb    <= 4'd0;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
      pcplus4_w    <= 32'd0;
      rd_w         <= 5'd0;
      regwrite_w   <= 1'b0;
      resultsrc_w  <= 2'd0;
      bus_err_w    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      case (r_state)
        IDLE: begin
          r_cnt <= 8'd0;
          r_err <= w_access & w_trap;
          if (w_access && !w_trap) begin
            bus_req   <= 1'b1;
            bus_we    <= memwrite_m;
            bus_addr  <= {alu_result_m[31:2], 2'b00};
            bus_wdata <= memwrite_m ? w_wdata : 32'd0;
            bus_wstrb <= memwrite_m ? w_wstrb : 4'd0;
            r_off     <= w_off;
            r_size    <= w_size;
            r_sign    <= ~funct3_m[2];
          end
        end
        BUS: begin
          // Ack on the final allowed cycle still completes normally.
          if (bus_ack) begin
            bus_req <= 1'b0;
            r_rdata <= bus_rdata;
          end else if (r_cnt == TO_LAST) begin
            bus_req <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase

      // MEM/WB register: a bubble (no write, no error) while stalled.
      alu_result_w <= alu_result_m;
      pcplus4_w    <= pcplus4_m;
      rd_w         <= rd_m;
      resultsrc_w  <= resultsrc_m;
      regwrite_w   <= ~stall_m & regwrite_m & ~((r_state == DONE) & r_err);
      bus_err_w    <= (r_state == DONE) & r_err;
      read_data_w  <= ((r_state == DONE) && !r_err && !bus_we) ? w_load_data : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Directed cases for
//               lane steering, load extension, wait states, timeout, late ack,
//               misalignment and reset, followed by randomized instructions
//               checked against a byte-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_m, write_data_m, pcplus4_m;
  logic [4:0]  rd_m;
  logic        regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m;
  logic [2:0]  funct3_m;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        stall_m;
  logic [31:0] alu_result_w, read_data_w, pcplus4_w;
  logic [4:0]  rd_w;
  logic        regwrite_w, bus_err_w;
  logic [1:0]  resultsrc_w;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
    .pcplus4_m(pcplus4_m), .regwrite_m(regwrite_m), .resultsrc_m(resultsrc_m),
    .memwrite_m(memwrite_m), .funct3_m(funct3_m),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .stall_m(stall_m),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w),
    .pcplus4_w(pcplus4_w), .rd_w(rd_w), .regwrite_w(regwrite_w),
    .resultsrc_w(resultsrc_w), .bus_err_w(bus_err_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_wstrb(input int off, input int n);
    int m;
    if (n == 4) return 4'hF;
    m = ((1 << n) - 1) << off;
    return 4'(m % 16);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int n);
    if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
    if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off, input logic [2:0] f3);
    longint v;
    int     n;
    n = nbytes(1'b0, f3);
    v = longint'(rd) / (longint'(1) << (8 * off));
    if (n == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (n == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // One instruction through MEM. ack_at = index of the BUS cycle that acks
  // (>= TO means no ack). Returns with MEM/WB holding the result.
  task automatic run(input string tag, input logic mw, input logic [1:0] rs,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic rw, input logic [4:0] rd,
                     input int ack_at, input logic [31:0] rdata);
    bit acc, st, trap, err, done;
    int n, off, k;
    alu_result_m = addr; write_data_m = wd; rd_m = rd; pcplus4_m = addr + 32'd4;
    regwrite_m = rw; resultsrc_m = rs; memwrite_m = mw; funct3_m = f3;
    acc  = mw || (rs == 2'b01);
    st   = mw;
    n    = nbytes(st, f3);
    off  = int'(addr[1:0]);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = acc && (off % n != 0);
`endif
    err = trap;
    #1;
    check({tag, " stall_idle"}, 32'(stall_m), 32'(acc));
    if (acc) begin
      if (!trap) begin
        tick;
        k = 0;
        done = 1'b0;
        while (!done) begin
          check({tag, " stall_bus"}, 32'(stall_m), 32'd1);
          check({tag, " bus_req"}, 32'(bus_req), 32'd1);
          check({tag, " bus_addr"}, bus_addr, {addr[31:2], 2'b00});
          check({tag, " bus_we"}, 32'(bus_we), 32'(st));
          check({tag, " bus_wstrb"}, 32'(bus_wstrb), st ? 32'(m_wstrb(off, n)) : 32'd0);
          if (st) check({tag, " bus_wdata"}, bus_wdata, m_wdata(wd, n));
          check({tag, " bubble_bus"}, 32'(regwrite_w), 32'd0);
          if (k == ack_at) begin
            bus_ack = 1'b1; bus_rdata = rdata; done = 1'b1;
          end else begin
            bus_ack = 1'b0; bus_rdata = $urandom;
            if (k == TO - 1) begin err = 1'b1; done = 1'b1; end
          end
          tick;
          k++;
        end
        bus_ack = 1'b0;
      end else begin
        tick;
      end
      check({tag, " stall_done"}, 32'(stall_m), 32'd0);
      check({tag, " req_done"}, 32'(bus_req), 32'd0);
      check({tag, " bubble_done"}, {31'd0, regwrite_w} | {31'd0, bus_err_w}, 32'd0);
    end
    tick;
    check({tag, " regwrite_w"}, 32'(regwrite_w), 32'(rw && !err));
    check({tag, " bus_err_w"}, 32'(bus_err_w), 32'(err));
    check({tag, " rd_w"}, 32'(rd_w), 32'(rd));
    check({tag, " alu_result_w"}, alu_result_w, addr);
    check({tag, " pcplus4_w"}, pcplus4_w, addr + 32'd4);
    check({tag, " resultsrc_w"}, 32'(resultsrc_w), 32'(rs));
    if (acc && !st) check({tag, " read_data_w"}, read_data_w, err ? 32'd0 : m_load(rdata, off, f3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=hang expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    int kind;
    reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    alu_result_m = 32'd0; write_data_m = 32'd0; rd_m = 5'd0; pcplus4_m = 32'd0;
    regwrite_m = 1'b0; resultsrc_m = 2'd0; memwrite_m = 1'b0; funct3_m = 3'd0;
    #3;
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset stall_m", 32'(stall_m), 32'd0);
    check("reset wb", alu_result_w | read_data_w | pcplus4_w | 32'(rd_w) |
          32'(regwrite_w) | 32'(resultsrc_w) | 32'(bus_err_w), 32'd0);
    check("reset bus", bus_addr | bus_wdata | 32'(bus_wstrb) | 32'(bus_we), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    tick;

    run("alu",   1'b0, 2'b00, 3'd0, 32'h1234_5678, 32'd0, 1'b1, 5'd5, 0, 32'd0);
    run("pc4",   1'b0, 2'b10, 3'd2, 32'h0000_0100, 32'd0, 1'b1, 5'd1, 0, 32'd0);
    run("rs11",  1'b0, 2'b11, 3'd1, 32'h0000_0203, 32'd0, 1'b1, 5'd9, 0, 32'd0);
    run("sb",    1'b1, 2'b00, 3'd0, 32'h0000_1002, 32'h0000_00A5, 1'b0, 5'd0, 0, 32'd0);
    run("lb",    1'b0, 2'b01, 3'd0, 32'h0000_2003, 32'd0, 1'b1, 5'd7, 0, 32'h80FF_FFFF);
    run("lhu",   1'b0, 2'b01, 3'd5, 32'h0000_2002, 32'd0, 1'b1, 5'd8, 0, 32'h80FF_FFFF);
    run("lw_ws", 1'b0, 2'b01, 3'd2, 32'h0000_2100, 32'd0, 1'b1, 5'd10, 2, 32'hCAFE_F00D);
    run("ack_last", 1'b0, 2'b01, 3'd2, 32'h0000_2104, 32'd0, 1'b1, 5'd11, TO - 1, 32'h1357_9BDF);
    run("tmo",   1'b0, 2'b01, 3'd2, 32'h0000_2200, 32'd0, 1'b1, 5'd12, TO, 32'h1111_2222);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    run("late_ack", 1'b0, 2'b00, 3'd0, 32'h0000_0044, 32'd0, 1'b1, 5'd13, 0, 32'd0);
    check("late_ack bus_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    run("lw_mis", 1'b0, 2'b01, 3'd2, 32'h0000_3001, 32'd0, 1'b1, 5'd14, 0, 32'hA1B2_C3D4);
    run("prio",  1'b1, 2'b01, 3'd1, 32'h0000_4002, 32'h0000_BEEF, 1'b0, 5'd15, 1, 32'd0);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = $urandom;
      if (kind == 0) begin
        run("rnd_alu", 1'b0, ($urandom_range(0, 3) == 1) ? 2'b00 : 2'($urandom_range(0, 3)),
            3'($urandom), a, $urandom, 1'($urandom), 5'($urandom), 0, 32'd0);
      end else if (kind == 1) begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 == 3'd3) f3 = 3'd7;
        run("rnd_ld", 1'b0, 2'b01, f3, a, $urandom, 1'($urandom), 5'($urandom),
            int'($urandom_range(0, TO)), $urandom);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        if (f3 == 3'd2) a[1:0] = 2'b00;
        run("rnd_st", 1'b1, 2'($urandom), f3, a, $urandom, 1'($urandom), 5'($urandom),
            int'($urandom_range(0, TO)), 32'd0);
      end
    end

    // Reset in the middle of a bus transfer.
    alu_result_m = 32'h0000_5000; resultsrc_m = 2'b01; memwrite_m = 1'b0;
    funct3_m = 3'd2; regwrite_m = 1'b1; rd_m = 5'd3;
    tick;
    check("rst_mid bus_req_before", 32'(bus_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid bus_req", 32'(bus_req), 32'd0);
    check("rst_mid stall_m", 32'(stall_m), 32'd0);
    check("rst_mid wb", alu_result_w | read_data_w | pcplus4_w | 32'(rd_w) |
          32'(regwrite_w) | 32'(resultsrc_w) | 32'(bus_err_w), 32'd0);
    resultsrc_m = 2'b00; regwrite_m = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    run("post_rst", 1'b0, 2'b01, 3'd4, 32'h0000_6001, 32'd0, 1'b1, 5'd2, 0, 32'h0000_9900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the 5-stage RV32 pipeline, directly downstream of the EX/MEM pipeline register. It consumes the registered EX/MEM fields and performs loads and stores over a req/ack data bus, stalling the upstream stages while a transfer is outstanding. It aligns and extends load data, then registers everything into the MEM/WB pipeline register for the writeback mux.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of BUS-state cycles without ack before the access aborts. Legal range 2..255.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- alu_result_m  in  32  effective address / ALU result from EX/MEM
- write_data_m  in  32  store data from EX/MEM
- rd_m  in  5  destination register
- pcplus4_m  in  32  PC+4
- regwrite_m  in  1  register write enable
- resultsrc_m  in  2  00 ALU, 01 load data, 10 PC+4, 11 treated as 00
- memwrite_m  in  1  store enable
- funct3_m  in  3  access size/sign
- bus_req  out  1  transfer request
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, bits[1:0] = 00
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables; 0000 on reads
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transfer complete
- stall_m  out  1  hold EX/MEM and earlier stages
- alu_result_w, read_data_w, pcplus4_w  out  32 each  MEM/WB fields
- rd_w  out  5;  regwrite_w  out  1;  resultsrc_w  out  2  MEM/WB fields
- bus_err_w  out  1  access aborted by timeout (one cycle, with the instruction)

## Operation
- Access = memwrite_m, or resultsrc_m == 01. memwrite_m has priority if both are set.
- FSM states: IDLE, BUS, DONE.
  - IDLE, no access: MEM/WB loads the inputs every cycle.
  - IDLE, access: stall_m = 1; latch address, wdata, wstrb, and we; go to BUS.
  - BUS: bus_req = 1 with latched fields; stall_m = 1.
    - On bus_ack: latch bus_rdata; go to DONE.
    - If TIMEOUT cycles pass without ack: set error flag; go to DONE.
  - DONE: stall_m = 0; MEM/WB loads the instruction; return to IDLE.
- While stall_m = 1, MEM/WB loads a bubble: regwrite_w = 0, bus_err_w = 0, other fields don't-care.
- Stores (funct3):
  - 000 SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - 001 SH: wdata = {2{half}}, wstrb = 0011 << addr[1:0].
  - 010 SW, and any other value: wstrb = 1111.
- Loads (funct3):
  - Shift rdata right by 8*addr[1:0].
  - 000 LB: sign-extend byte. 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half. 101 LHU: zero-extend half.
  - 010 LW and reserved values: full word.
- A timeout aborts the access: read_data_w = 0, regwrite_w = 0, bus_err_w = 1.
- bus_ack outside BUS is ignored.
- The RF writeback mux is not in this block.

## Timing
- Reset (async, immediate), all outputs cleared:
  - state = IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb = 0.
  - stall_m = 0; all _w outputs = 0; timeout counter = 0.
- Reset asserted in BUS drops bus_req immediately; the transfer is abandoned.
- Non-memory instruction: 1 cycle in MEM, no stall.
- Memory access with ack in the first BUS cycle: 3 cycles (IDLE, BUS, DONE); stall_m is high for 2 cycles.
- Each extra wait cycle adds 1 cycle.
- Timeout fires on the TIMEOUT-th BUS cycle without ack.
- Ack arriving on that same cycle wins; no error is raised.
- stall_m is a combinational function of state and the access decode in IDLE.
- All other outputs are registered.
- Bus fields are stable for the whole BUS state.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses never reach the bus. Misaligned = halfword with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - The FSM goes IDLE → DONE (1 stall cycle).
  - In DONE: regwrite_w = 0 and bus_err_w = 1.
- MEM_MISALIGN_TRAP_EN undefined:
  - Misaligned accesses proceed on the bus using the aligned word address.
  - Strobes and shifts are computed from addr[1:0], and bits shifted past lane 3 are dropped.
  - No error is raised.

## Test plan
- Reset check: assert reset during BUS → bus_req = 0 immediately; all _w outputs = 0; state = IDLE after release.
- Byte-store lane steering: SB of write_data = 0x000000A5 at addr 0x1002 → bus_addr = 0x1000, wstrb = 0100, wdata = 0xA5A5A5A5, stall_m high 2 cycles.
- Load sign/zero extension: LB at 0x2003 with rdata = 0x80FFFFFF → read_data_w = 0xFFFFFF80. LHU at 0x2002 with the same rdata → 0x000080FF.
- Wait states: ack after 3 BUS cycles for an LW → stall_m high 4 cycles; read_data_w = rdata; exactly one regwrite_w = 1 pulse.
- Timeout: no ack with TIMEOUT = 4 → abort after 4 BUS cycles; bus_err_w = 1 for one cycle; regwrite_w = 0. A late ack in IDLE is ignored.
- Misaligned LW at 0x3001:
  - With MEM_MISALIGN_TRAP_EN: bus_req never asserts; bus_err_w = 1.
  - Without it: bus_addr = 0x3000; read_data_w = rdata >> 8.
